// File: rtl/prog_loader.sv
// prog_loader: boot loader that turns a little-endian byte stream into 32-bit setup writes and holds the core until done.
// Define PROG_LOADER_CHECKSUM_EN to require and verify a trailing 32-bit sum of the data words.
module prog_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        setup_write,
   output logic [31:0] setup_address,
   output logic [31:0] setup_data_in,
   output logic        core_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);
`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR} state_t;
   localparam state_t TAIL = CSUM;
   logic [31:0] acc_q, acc_d;
`else
   typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERROR} state_t;
   localparam state_t TAIL = DONE;
`endif
   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] sh_q, sh_d, n_q, n_d, idx_q, idx_d, addr_q, addr_d, data_q, data_d;
   logic        done_q, done_d, error_q, error_d, hold_q, hold_d, busy_q, busy_d;
   logic        ready_q, ready_d, write_q, write_d, take, last;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      n_d     = n_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = done_q;
      error_d = error_q;
      hold_d  = hold_q;
      busy_d  = busy_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_d   = acc_q;
`endif
      take = byte_valid && ready_q;
      last = take && cnt_q == 2'd3;
      // bytes arrive LSB first, so shifting in from the top leaves the word in place after four bytes
      if (take) begin
         sh_d  = {byte_data, sh_q[31:8]};
         cnt_d = cnt_q + 2'd1;
      end
      case (state_q)
         IDLE, DONE, ERROR: if (start) begin
            state_d = LEN;
            done_d  = 1'b0;
            error_d = 1'b0;
            hold_d  = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = 2'd0;
            idx_d   = 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_d   = 32'd0;
`endif
         end
         LEN: if (last) begin
            n_d     = sh_d;
            state_d = sh_d > 32'(MAX_WORDS) ? ERROR : sh_d == 32'd0 ? TAIL : DATA;
         end
         DATA: if (last) begin
            state_d = WRITE;
            addr_d  = BASE_ADDR + {idx_q[29:0], 2'b00};
            data_d  = sh_d;
         end
         WRITE: begin
            idx_d   = idx_q + 32'd1;
            state_d = idx_d < n_q ? DATA : TAIL;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_d   = acc_q + data_q;
`endif
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CSUM: if (last) state_d = sh_d == acc_q ? DONE : ERROR;
`endif
         default: ;
      endcase
      if (state_d == DONE && state_q != DONE) begin
         done_d = 1'b1;
         hold_d = 1'b0;
         busy_d = 1'b0;
      end
      if (state_d == ERROR && state_q != ERROR) begin
         error_d = 1'b1;
         busy_d  = 1'b0;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ready_d = state_d == LEN || state_d == DATA || state_d == CSUM;
`else
      ready_d = state_d == LEN || state_d == DATA;
`endif
      write_d = state_d == WRITE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         sh_q    <= 32'd0;
         n_q     <= 32'd0;
         idx_q   <= 32'd0;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         hold_q  <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         write_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         acc_q   <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         error_q <= error_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         write_q <= write_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         acc_q   <= acc_d;
`endif
      end
   end

   assign byte_ready    = ready_q;
   assign setup_write   = write_q;
   assign setup_address = addr_q;
   assign setup_data_in = data_q;
   assign core_hold     = hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
endmodule
